sigmf_bp: RTL and testbench

SIGMF_BP -- requirements
Module: sigmf_bp

---
 rtl/sigmf_bp.sv | 129 ++++++++++++
 tb/tb_sigmf_bp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sigmf_bp.sv
// Sigmoid backprop: o_grad = delta * y * (1 - y) using one iterative signed shift-add multiplier.
// Optional macro SIGMF_BP_CLAMP_EN clamps the captured y to [0, 1.0].
module sigmf_bp #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_y,
   input  logic [WIDTH-1:0] i_delta,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_grad
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL1 = 2'd1;
   localparam logic [1:0] MUL2 = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

   logic [1:0]         state_reg;
   logic [CW-1:0]      cnt_reg;
   logic [WIDTH-1:0]   y_reg;
   logic [WIDTH-1:0]   delta_reg;
   logic [WIDTH-1:0]   om_reg;
   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   grad_reg;

   logic [WIDTH-1:0]   y_cap;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] sum;
   logic [WIDTH-1:0]   slice;
   logic               last;

   always_comb begin
`ifdef SIGMF_BP_CLAMP_EN
      if (i_y[WIDTH-1])
         y_cap = '0;
      else if (i_y > ONE)
         y_cap = ONE;
      else
         y_cap = i_y;
`else
      y_cap = i_y;
`endif
   end

   // The multiplier's top bit carries negative weight, so the final step subtracts.
   assign last   = (cnt_reg == LAST_CNT);
   assign addend = mplier_reg[0] ? mcand_reg : '0;
   assign sum    = last ? (acc_reg - addend) : (acc_reg + addend);
   assign slice  = sum[FRAC+WIDTH-1:FRAC];

   assign i_ready = (state_reg == IDLE);
   assign o_valid = (state_reg == DONE);
   assign o_grad  = grad_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         y_reg      <= '0;
         delta_reg  <= '0;
         om_reg     <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         grad_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_valid) begin
                  y_reg     <= y_cap;
                  delta_reg <= i_delta;
                  om_reg    <= ONE - y_cap;
                  cnt_reg   <= '0;
                  state_reg <= MUL1;
               end
            end
            MUL1: begin
               if (cnt_reg == '0) begin
                  // Load cycle: operands move from capture registers into the multiplier.
                  mcand_reg  <= {{WIDTH{y_reg[WIDTH-1]}}, y_reg};
                  mplier_reg <= om_reg;
                  acc_reg    <= '0;
                  cnt_reg    <= CW'(1);
               end else if (last) begin
                  mcand_reg  <= {{WIDTH{delta_reg[WIDTH-1]}}, delta_reg};
                  mplier_reg <= slice;
                  acc_reg    <= '0;
                  cnt_reg    <= CW'(1);
                  state_reg  <= MUL2;
               end else begin
                  acc_reg    <= sum;
                  mcand_reg  <= mcand_reg << 1;
                  mplier_reg <= mplier_reg >> 1;
                  cnt_reg    <= cnt_reg + CW'(1);
               end
            end
            MUL2: begin
               if (last) begin
                  grad_reg  <= slice;
                  cnt_reg   <= '0;
                  state_reg <= DONE;
               end else begin
                  acc_reg    <= sum;
                  mcand_reg  <= mcand_reg << 1;
                  mplier_reg <= mplier_reg >> 1;
                  cnt_reg    <= cnt_reg + CW'(1);
               end
            end
            DONE: begin
               if (o_ready)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sigmf_bp.sv
// Randomized self-checking bench for sigmf_bp against a plain-arithmetic reference model.
module tb_sigmf_bp;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_y;
   logic [31:0] i_delta;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_grad;

   int total = 0;
   int bad   = 0;

   sigmf_bp #(.WIDTH(32), .FRAC(24)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_y     (i_y),
      .i_delta (i_delta),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_grad  (o_grad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Fixed-point reference: full 64-bit products, arithmetic shift, keep low 32 bits.
   function automatic logic [31:0] model(input logic [31:0] y_in, input logic [31:0] dl);
      longint ys, om, p, dd, g;
      logic [31:0] y, om32, d32;
      y = y_in;
`ifdef SIGMF_BP_CLAMP_EN
      if ($signed(y) < 0) y = 32'h0;
      else if ($signed(y) > 32'sh01000000) y = 32'h01000000;
`endif
      om32 = 32'h01000000 - y;
      ys = longint'($signed(y));
      om = longint'($signed(om32));
      p = (ys * om) >>> 24;
      d32 = p[31:0];
      dd = longint'($signed(d32));
      g = (longint'($signed(dl)) * dd) >>> 24;
      return g[31:0];
   endfunction

   task automatic run_txn(input logic [31:0] y, input logic [31:0] dl,
                          input logic [31:0] exp, input int hold);
      int n;
      n = 0;
      while (!i_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("ready_wait", {31'd0, i_ready}, 32'd1);
      i_valid = 1'b1;
      i_y     = y;
      i_delta = dl;
      @(negedge clk);
      i_valid = 1'b0;
      i_y     = $urandom;
      i_delta = $urandom;
      n = 0;
      while (!o_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("latency", 32'(n), 32'd65);
      check_val("grad", o_grad, exp);
      for (int k = 0; k < hold; k++) begin
         i_valid = 1'($urandom_range(0, 1));
         i_y     = $urandom;
         i_delta = $urandom;
         check_val("busy_rdy", {31'd0, i_ready}, 32'd0);
         @(negedge clk);
         check_val("hold_valid", {31'd0, o_valid}, 32'd1);
         check_val("hold_grad", o_grad, exp);
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      check_val("rel_rdy", {31'd0, i_ready}, 32'd0);
      @(negedge clk);
      o_ready = 1'b0;
      check_val("post_valid", {31'd0, o_valid}, 32'd0);
      check_val("post_rdy", {31'd0, i_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] y, dl, e;
      int n;
      rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; i_y = '0; i_delta = '0;
      repeat (3) @(negedge clk);
      check_val("rst_rdy", {31'd0, i_ready}, 32'd1);
      check_val("rst_valid", {31'd0, o_valid}, 32'd0);
      check_val("rst_grad", o_grad, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_txn(32'h00800000, 32'h01000000, 32'h00400000, 0);
      run_txn(32'h00C00000, 32'hFE000000, 32'hFFA00000, 0);
`ifdef SIGMF_BP_CLAMP_EN
      run_txn(32'hFF800000, 32'h01000000, 32'h00000000, 0);
`else
      run_txn(32'hFF800000, 32'h01000000, 32'hFF400000, 0);
`endif
      run_txn(32'h00000000, $urandom, 32'h0, 0);
      run_txn(32'h01000000, $urandom, 32'h0, 0);

      // Long stall with junk on the input side; no second result may appear.
      run_txn(32'h00800000, 32'h01000000, 32'h00400000, 10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("no_extra", {31'd0, o_valid}, 32'd0);
      end

      // Abort mid-MUL1, then an all-zero result must follow.
      i_valid = 1'b1; i_y = 32'h00400000; i_delta = 32'h01000000;
      @(negedge clk);
      i_valid = 1'b0;
      for (int k = 0; k < 19; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("abort_rdy", {31'd0, i_ready}, 32'd1);
      check_val("abort_valid", {31'd0, o_valid}, 32'd0);
      check_val("abort_grad", o_grad, 32'd0);
      n = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (o_valid) n++;
      end
      check_val("stale_valid", 32'(n), 32'd0);
      run_txn(32'h00000000, 32'h7FFFFFFF, 32'h0, 0);

      // Randomized back-to-back traffic.
      for (int t = 0; t < 24; t++) begin
         case ($urandom_range(0, 3))
            0: y = $urandom_range(0, 32'h01000000);
            1: y = $urandom;
            2: y = 32'hFF000000 + $urandom_range(0, 32'h00FFFFFF);
            default: y = 32'h01000000 + $urandom_range(0, 32'h00FFFFFF);
         endcase
         dl = $urandom;
         e = model(y, dl);
         run_txn(y, dl, e, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
